mpx_muldiv: RTL
===============

// Module: mpx_muldiv
// PURPOSE
//  Multi-cycle multiply/divide unit and HI/LO register file for the MPX execute stage.
//  Sequences MULT/MULTU/DIV/DIVU, serves MFHI/MFLO/MTHI/MTLO, and interlocks the pipeline
//  by raising stall_o while a result is pending. It sits beside the execute ALU and sees
//  the same decoded opcode/operand bus; the execute writeback mux selects its result.
// PARAMETERS
//  MUL_LATENCY  3   busy cycles for MULT/MULTU (legal range 1..8)
// PORTS
//  clk_i                i  1   clock, all state on rising edge
//  rst_i                i  1   reset, asynchronous, active-low
//  opcode_valid_i       i  1   opcode/operands below are valid this cycle
//  opcode_opcode_i      i  32  instruction word; [31:26]=0 SPECIAL, [5:0]=func
//  opcode_rs_operand_i  i  32  rs value (dividend / multiplicand / MTHI-MTLO source)
//  opcode_rt_operand_i  i  32  rt value (divisor / multiplier)
//  hold_i               i  1   pipeline hold; blocks acceptance, freezes writeback_value_o
//  squash_i             i  1   exception flush: abort in-flight op, HI/LO unchanged
//  stall_o              o  1   interlock request to the pipeline (combinational)
//  busy_o               o  1   operation in flight (registered)
//  writeback_value_o    o  32  MFHI/MFLO result (registered)
// BEHAVIOUR
//  Ops (SPECIAL func): MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19,
//   DIV 0x1A, DIVU 0x1B. Any other opcode is ignored: no state change, no stall.
//  md_op = opcode_valid_i & SPECIAL & func in the set above.
//  stall_o = md_op & busy_o. Every md_op interlocks on a busy unit, including MTxx and new MULT/DIV.
//  accept = md_op & ~busy_o & ~hold_i & ~squash_i. Nothing is accepted otherwise.
//  Reset: state=IDLE, HI=LO=0, count=0, busy_o=0, writeback_value_o=0; stall_o follows busy_o=0.
//  FSM states: IDLE, MUL, DIV, FIX.
//   IDLE -> MUL on accepted MULT/MULTU: load count=MUL_LATENCY.
//   IDLE -> DIV on accepted DIV/DIVU: load |rs|, |rt| (signed) or raw (unsigned), count=32.
//   MUL: count decrements each cycle. At the count==1 edge: {HI,LO}=64-bit product, go IDLE.
//   DIV: one restoring step per cycle, 32 steps, then -> FIX.
//   FIX (1 cycle): signed ops apply fixups. Quotient negated if rs[31]^rt[31]; remainder
//    negated if rs[31]. Then LO=quotient, HI=remainder, go IDLE.
//  busy_o=1 in MUL/DIV/FIX. MULT is busy for MUL_LATENCY cycles after the accept edge; DIV is busy for 33.
//  An md_op presented in the first cycle busy_o=0 is accepted and sees the new HI/LO.
//  MULT signed: 64-bit two's-complement product. MULTU: unsigned.
//  Divide by zero (rt==0): no exception. Result is LO=32'hFFFFFFFF, HI=rs, for both DIV and
//   DIVU, with no sign fixup.
//  DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
//  MTHI/MTLO: HI/LO <= rs at the accept edge, 1 cycle, busy_o stays 0.
//  MFHI/MFLO: writeback_value_o <= HI/LO at the accept edge, visible the next cycle.
//  writeback_value_o otherwise holds its value. It never changes while hold_i=1.
//  hold_i does not pause MUL/DIV/FIX; the sequencer keeps counting under hold.
//  squash_i: state -> IDLE, busy_o -> 0 next edge, HI/LO keep their pre-op values.
//   squash_i has priority over completion in the same cycle.
//  Multiplier/divider operand registers are loaded only on accept. Operand inputs may change
//   while busy.
// TESTING
//  MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF, then MFHI/MFLO -> HI=0xFFFFFFFE, LO=0x00000001;
//   busy_o high exactly MUL_LATENCY cycles.
//  MULT rs=-3 rt=7, MFLO issued next cycle -> stall_o high MUL_LATENCY cycles, then
//   writeback_value_o=0xFFFFFFEB, HI=0xFFFFFFFF.
//  DIV rs=-7 rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 33 busy cycles;
//   DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
//  DIV 0x80000000/-1 -> LO=0x80000000, HI=0. MTHI 0x1234 while DIV busy -> stalls,
//   then HI=0x1234 (overwrites DIV result).
//  squash_i at DIV cycle 10 -> busy_o=0 next cycle, HI/LO unchanged. Async rst_i low mid-MULT
//   -> all outputs 0 immediately.
//  hold_i=1 across a MFLO accept window -> no accept, stall_o=0 when idle,
//   writeback_value_o frozen; hold_i=1 during MULT -> completion still at MUL_LATENCY.

Source files
------------

// File: rtl/mpx_muldiv.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the MPX execute stage.
// Multiplies complete after MUL_LATENCY cycles; divides take 32 restoring steps plus a sign-fixup cycle.
module mpx_muldiv #(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic [31:0] opcode_rs_operand_i,
  input  logic [31:0] opcode_rt_operand_i,
  input  logic        hold_i,
  input  logic        squash_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] writeback_value_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, wb_q, wb_d;
  logic [XLEN-1:0]   opa_q, opa_d, opb_q, opb_d, rem_q, rem_d;
  logic              mul_sgn_q, mul_sgn_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic              busy_q, busy_d;

  logic [5:0]        func;
  logic              special, known_func, md_op, accept, div_signed;
  logic              unused_opcode_bits;

  assign func               = opcode_opcode_i[5:0];
  assign special            = (opcode_opcode_i[31:26] == 6'd0);
  assign unused_opcode_bits = ^opcode_opcode_i[25:6];
  assign div_signed         = (func == FN_DIV);

  always_comb begin
    known_func = 1'b0;
    case (func)
      FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
      FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: known_func = 1'b1;
      default:                             known_func = 1'b0;
    endcase
  end

  assign md_op   = opcode_valid_i & special & known_func;
  assign accept  = md_op & ~busy_q & ~hold_i & ~squash_i;
  assign stall_o = md_op & busy_q;

  // Full 64-bit product of the latched operands; sign-extended for MULT.
  logic [2*XLEN-1:0] opa_ext, opb_ext, product;
  assign opa_ext = mul_sgn_q ? {{XLEN{opa_q[XLEN-1]}}, opa_q} : {{XLEN{1'b0}}, opa_q};
  assign opb_ext = mul_sgn_q ? {{XLEN{opb_q[XLEN-1]}}, opb_q} : {{XLEN{1'b0}}, opb_q};
  assign product = opa_ext * opb_ext;

  // Restoring step: dividend bits shift out of opa_q while quotient bits shift in.
  logic [XLEN:0] partial;
  logic          fits;
  assign partial = {rem_q, opa_q[XLEN-1]};
  assign fits    = (partial >= {1'b0, opb_q});

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    wb_d      = wb_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    mul_sgn_d = mul_sgn_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;

    if (squash_i) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (func)
              FN_MFHI: wb_d = hi_q;
              FN_MFLO: wb_d = lo_q;
              FN_MTHI: hi_d = opcode_rs_operand_i;
              FN_MTLO: lo_d = opcode_rs_operand_i;
              FN_MULT, FN_MULTU: begin
                state_d   = ST_MUL;
                count_d   = CNT_W'(MUL_LATENCY);
                opa_d     = opcode_rs_operand_i;
                opb_d     = opcode_rt_operand_i;
                mul_sgn_d = (func == FN_MULT);
              end
              FN_DIV, FN_DIVU: begin
                state_d = ST_DIV;
                count_d = CNT_W'(XLEN);
                rem_d   = '0;
                opa_d   = (div_signed && opcode_rs_operand_i[XLEN-1]) ?
                          -opcode_rs_operand_i : opcode_rs_operand_i;
                opb_d   = (div_signed && opcode_rt_operand_i[XLEN-1]) ?
                          -opcode_rt_operand_i : opcode_rt_operand_i;
                // Divide by zero keeps the raw all-ones quotient; remainder fixup restores rs.
                q_neg_d = div_signed && (opcode_rs_operand_i[XLEN-1] ^ opcode_rt_operand_i[XLEN-1])
                          && (opcode_rt_operand_i != '0);
                r_neg_d = div_signed && opcode_rs_operand_i[XLEN-1];
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            hi_d    = product[2*XLEN-1:XLEN];
            lo_d    = product[XLEN-1:0];
            state_d = ST_IDLE;
          end
        end
        ST_DIV: begin
          count_d = count_q - CNT_W'(1);
          rem_d   = fits ? XLEN'(partial - {1'b0, opb_q}) : partial[XLEN-1:0];
          opa_d   = {opa_q[XLEN-2:0], fits};
          if (count_q == CNT_W'(1)) state_d = ST_FIX;
        end
        ST_FIX: begin
          lo_d    = q_neg_q ? -opa_q : opa_q;
          hi_d    = r_neg_q ? -rem_q : rem_q;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      wb_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      rem_q     <= '0;
      mul_sgn_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      wb_q      <= wb_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rem_q     <= rem_d;
      mul_sgn_q <= mul_sgn_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      busy_q    <= busy_d;
    end
  end

  assign busy_o            = busy_q;
  assign writeback_value_o = wb_q;

endmodule
